// File: rtl/julia_writer.sv
// Pixel writeback stage: queues finished Julia pixels as framebuffer byte writes
// and drains them to the memory bus with a req/ack handshake, back-pressuring the worker.
module julia_writer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter logic [31:0] BASE  = 32'h08000000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        JW_done,
  input  logic [7:0]  pixel,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        MC_busy,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  input  logic        wr_ack,
  output logic        overflow,
  output logic        range_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] W_HRES = 32'(H_RES);
  localparam logic [31:0] W_VRES = 32'(V_RES);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [29:0]   r_mem_addr [DEPTH];
  logic [3:0]    r_mem_be   [DEPTH];
  logic [7:0]    r_mem_pix  [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  state_t        r_state;

  logic [31:0]   w_addr;
  logic [3:0]    w_be;
  logic          w_in_range;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rptr_next;

  assign w_addr      = BASE + 32'(y) * W_HRES + 32'(x);
  assign w_be        = 4'b0001 << w_addr[1:0];
  assign w_in_range  = (32'(x) < W_HRES) && (32'(y) < W_VRES);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = (r_state == S_REQ) && wr_ack;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_push      = JW_done && w_in_range && (!w_full || w_pop);
  assign w_rptr_next = r_rptr + AW'(1);

  assign MC_busy = w_full;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_state   <= S_IDLE;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_be     <= '0;
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_addr[r_wptr] <= w_addr[31:2];
        r_mem_be[r_wptr]   <= w_be;
        r_mem_pix[r_wptr]  <= pixel;
        r_wptr             <= r_wptr + AW'(1);
      end

      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);

      if (JW_done && !w_in_range)
        range_err <= 1'b1;
      else if (JW_done && w_full && !w_pop)
        overflow <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            wr_addr <= {r_mem_addr[r_rptr], 2'b00};
            wr_be   <= r_mem_be[r_rptr];
            wr_data <= {4{r_mem_pix[r_rptr]}};
            wr_req  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_ack) begin
            r_rptr <= w_rptr_next;
            // Head is still counted here; >1 means another entry is already stored
            if (r_count > CW'(1)) begin
              wr_addr <= {r_mem_addr[w_rptr_next], 2'b00};
              wr_be   <= r_mem_be[w_rptr_next];
              wr_data <= {4{r_mem_pix[w_rptr_next]}};
            end else begin
              wr_req  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_writer.sv
// Bench for julia_writer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_julia_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;
  localparam logic [31:0] BASE  = 32'h08000000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        JW_done = 1'b0;
  logic [7:0]  pixel = '0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        wr_ack = 1'b0;
  logic        MC_busy;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        overflow;
  logic        range_err;

  int n_cmp = 0;
  int n_bad = 0;

  julia_writer #(.DEPTH(DEPTH), .H_RES(H_RES), .V_RES(V_RES), .BASE(BASE)) dut (
    .clk(clk), .n_rst(n_rst), .JW_done(JW_done), .pixel(pixel), .x(x), .y(y),
    .MC_busy(MC_busy), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_ack(wr_ack), .overflow(overflow), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels waiting for the bus, plus the write being presented
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t  m_q[$];
  wr_t  m_out;
  bit   m_busy = 0;
  bit   m_ovf = 0;
  bit   m_rng = 0;
  bit   model_valid = 0;

  function automatic wr_t mk(input int unsigned xx, input int unsigned yy, input logic [7:0] p);
    wr_t e;
    longint unsigned a;
    logic [31:0] a32;
    a = longint'(BASE) + longint'(yy) * H_RES + xx;
    a32 = a[31:0];
    e.addr = {a32[31:2], 2'b00};
    e.be   = 4'(1 << a32[1:0]);
    e.data = {p, p, p, p};
    return e;
  endfunction

  always @(posedge clk) begin
    int  cnt;
    bit  pop;
    bit  push;
    if (n_rst) begin
      m_q.delete();
      m_busy = 0;
      m_ovf = 0;
      m_rng = 0;
      model_valid = 1;
    end else begin
      cnt  = m_q.size();
      pop  = m_busy && wr_ack;
      push = 0;
      if (JW_done) begin
        if (x >= H_RES || y >= V_RES) m_rng = 1;
        else if (cnt < DEPTH || pop)  push = 1;
        else                          m_ovf = 1;
      end
      if (!m_busy) begin
        if (cnt > 0) begin
          m_busy = 1;
          m_out  = m_q[0];
        end
      end else if (wr_ack) begin
        void'(m_q.pop_front());
        if (m_q.size() > 0) m_out = m_q[0];
        else                m_busy = 0;
      end
      if (push) m_q.push_back(mk(x, y, pixel));
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("wr_req", wr_req, m_busy);
      check("MC_busy", MC_busy, (m_q.size() == DEPTH));
      check("overflow", overflow, m_ovf);
      check("range_err", range_err, m_rng);
      if (m_busy) begin
        check("wr_addr", wr_addr, m_out.addr);
        check("wr_be", wr_be, m_out.be);
        check("wr_data", wr_data, m_out.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned xx, input int unsigned yy, input logic [7:0] p);
    JW_done = 1'b1;
    x = 10'(xx);
    y = 10'(yy);
    pixel = p;
    cyc();
    JW_done = 1'b0;
  endtask

  task automatic do_reset(input int n);
    n_rst = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    n_rst = 1'b0;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim && !wr_req; i++) cyc();
    check("wait_req", wr_req, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wr_req"}, wr_req, 0);
    check({tag, ".wr_addr"}, wr_addr, 0);
    check({tag, ".wr_data"}, wr_data, 0);
    check({tag, ".wr_be"}, wr_be, 0);
    check({tag, ".MC_busy"}, MC_busy, 0);
    check({tag, ".overflow"}, overflow, 0);
    check({tag, ".range_err"}, range_err, 0);
  endtask

  initial begin
    #2;
    // Reset state
    do_reset(2);
    check_all_zero("reset");

    // Single pixel, ack tied high
    wr_ack = 1'b1;
    pulse(5, 2, 8'hA5);
    check("single.N+1 req", wr_req, 0);
    cyc();
    check("single.req", wr_req, 1);
    check("single.addr", wr_addr, 32'h08000504);
    check("single.be", wr_be, 4'b0010);
    check("single.data", wr_data, 32'hA5A5A5A5);
    cyc();
    check("single.req_drop", wr_req, 0);
    wr_ack = 1'b0;

    // Fill, overflow, then back-to-back drain
    do_reset(1);
    for (int i = 0; i < 4; i++) pulse(i, 0, 8'(8'h10 + i));
    check("fill.busy", MC_busy, 1);
    pulse(4, 0, 8'h55);
    check("fill.overflow", overflow, 1);
    check("fill.busy_hold", MC_busy, 1);
    check("fill.req", wr_req, 1);
    wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] be_exp;
      be_exp = 4'b0001 << i;
      check("drain.req", wr_req, 1);
      check("drain.addr", wr_addr, 32'h08000000);
      check("drain.be", wr_be, be_exp);
      if (i == 1) check("drain.busy_fall", MC_busy, 0);
      cyc();
    end
    check("drain.idle", wr_req, 0);
    wr_ack = 1'b0;

    // Push and pop together while full
    do_reset(1);
    for (int i = 0; i < 4; i++) pulse(i + 8, 1, 8'(8'h20 + i));
    wait_req(4);
    check("simul.full", MC_busy, 1);
    JW_done = 1'b1;
    x = 10'd20;
    y = 10'd3;
    pixel = 8'h77;
    wr_ack = 1'b1;
    cyc();
    JW_done = 1'b0;
    wr_ack = 1'b0;
    check("simul.overflow", overflow, 0);
    check("simul.still_full", MC_busy, 1);
    wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    check("simul.drained", wr_req, 0);
    wr_ack = 1'b0;

    // Range error and bottom-right corner
    pulse(640, 0, 8'h99);
    check("range.err", range_err, 1);
    cyc();
    cyc();
    check("range.nowrite", wr_req, 0);
    pulse(639, 479, 8'h3C);
    wait_req(4);
    check("corner.addr", wr_addr, 32'h0804AFFC);
    check("corner.be", wr_be, 4'b1000);
    check("corner.data", wr_data, 32'h3C3C3C3C);
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;

    // Reset in the middle of a transfer
    for (int i = 0; i < 3; i++) pulse(i, 5, 8'(8'h40 + i));
    wait_req(4);
    do_reset(1);
    check_all_zero("midrst");
    wr_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("midrst.nowrite", wr_req, 0);
    end
    wr_ack = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      n_rst   = ($urandom_range(0, 499) == 0);
      JW_done = ($urandom_range(0, 99) < 45);
      x       = 10'($urandom_range(0, 700));
      y       = 10'($urandom_range(0, 520));
      pixel   = 8'($urandom);
      wr_ack  = ($urandom_range(0, 99) < 50);
      cyc();
    end
    n_rst = 1'b0;
    JW_done = 1'b0;
    wr_ack = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("final.empty", wr_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/julia_writer.md
# julia_writer

Downstream stage of the Julia worker: captures each finished pixel on `JW_done`, converts its (x, y) screen coordinate to a framebuffer byte address and queues it in a small FIFO. It then drains the FIFO to the memory bus with a request/acknowledge handshake. It generates the `MC_busy` back-pressure the worker consumes, so a slow memory stalls pixel production instead of losing pixels.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `BASE`, 32'h08000000: framebuffer byte base address.

- `clk`  in  1  system clock; all logic on the rising edge.
- `n_rst`  in  1  reset; synchronous, active-high (asserted = 1) despite the name.
- `JW_done`  in  1  one-cycle pulse: `pixel`, `x` and `y` are valid this cycle.
- `pixel`  in  8  finished pixel value.
- `x`  in  10  column of the finished pixel.
- `y`  in  10  row of the finished pixel.
- `MC_busy`  out  1  FIFO full; worker must not pulse `JW_done`.
- `wr_req`  out  1  bus write request.
- `wr_addr`  out  32  word-aligned byte address (bits [1:0] = 0).
- `wr_data`  out  32  pixel replicated into all four bytes.
- `wr_be`  out  4  byte enable, one-hot.
- `wr_ack`  in  1  bus accepted the current request this cycle.
- `overflow`  out  1  sticky: a `JW_done` was dropped because the FIFO was full.
- `range_err`  out  1  sticky: a `JW_done` was dropped because x ≥ H_RES or y ≥ V_RES.

## Operation
- **Address:** `a = BASE + y*H_RES + x`, computed modulo 2^32 (unsigned).
  - `wr_addr = {a[31:2], 2'b00}`.
  - `wr_be = 4'b0001 << a[1:0]`.
  - `wr_data = {4{pixel}}`.
- **FIFO:** DEPTH entries of {word address, byte enable, pixel}, with registered count 0..DEPTH.
  - A push occurs on `JW_done` when the coordinate is in range and either count < DEPTH or a pop happens in the same cycle.
  - `JW_done` with count == DEPTH and no same-cycle pop: drop the pixel and set `overflow`.
  - Out-of-range coordinate: drop the pixel and set `range_err`. The range check takes priority over the full check.
  - A push and a pop in the same cycle leave count unchanged.
- **`MC_busy`:** `MC_busy = (count == DEPTH)`, decoded from the count register.
- **Bus FSM, two states:**
  - IDLE: if count > 0, load the head entry into the output registers, assert `wr_req`, go to REQ.
  - REQ: `wr_req`, `wr_addr`, `wr_data` and `wr_be` stay stable until `wr_ack`.
  - On `wr_ack`: pop the head entry.
    - If one or more entries remain after the pop, load the next entry the following cycle and stay in REQ (back-to-back writes, no bubble).
    - Otherwise drop `wr_req` and go to IDLE.
  - `wr_ack` seen while in IDLE is ignored.
- **Sticky flags:** `overflow` and `range_err` clear only on reset.
- **Reset:** takes priority over all events in the same cycle.
  - Any in-flight request is abandoned and every queued pixel is discarded.
  - Outputs: `wr_req` = 0, `wr_addr` = 0, `wr_data` = 0, `wr_be` = 0, `MC_busy` = 0, `overflow` = 0, `range_err` = 0. FSM returns to IDLE with count = 0.

## Timing
- **Latency:** with the FIFO empty and the FSM in IDLE, `JW_done` in cycle N gives `wr_req` = 1 in cycle N+2.
  - N+1: entry written, count = 1.
  - N+2: FSM loads the entry and raises `wr_req`.
- **Back-pressure:** `MC_busy` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the first pop from full.
- **Throughput:** one write per cycle while `wr_ack` stays high and the FIFO is non-empty.
- **Outputs:** `wr_*` and `MC_busy` are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `n_rst` = 1 for 2 cycles -> all outputs 0; FIFO empty.
- **Single pixel:** `JW_done`, x = 5, y = 2, pixel = 8'hA5, `wr_ack` tied high -> exactly 2 cycles later `wr_req` = 1, `wr_addr` = 32'h08000504, `wr_be` = 4'b0010, `wr_data` = 32'hA5A5A5A5; `wr_req` is 0 the cycle after the ack.
- **Fill and stall:** `wr_ack` = 0; 4 pulses (x = 0..3, y = 0) -> `MC_busy` = 1 after the 4th push.
  - A 5th pulse sets `overflow` = 1 and count stays at 4.
  - Release `wr_ack` -> 4 back-to-back writes, all to `wr_addr` = 32'h08000000 with `wr_be` 0001, 0010, 0100, 1000, in that order; `MC_busy` falls after the first ack.
- **Simultaneous push/pop at full:** FIFO full, `wr_ack` = 1 and `JW_done` in the same cycle -> pixel accepted, `overflow` unchanged, count stays at 4.
- **Range and corner:**
  - x = 640, y = 0 -> dropped, `range_err` = 1, no write.
  - x = 639, y = 479 -> `wr_addr` = 32'h0804AFFC, `wr_be` = 4'b1000.
- **Reset mid-transfer:** 3 entries queued, `wr_req` high, assert `n_rst` for 1 cycle -> `wr_req` = 0, FIFO empty; no further writes after reset is released.
